// File: rtl/seq_emitter_if.sv
// Stimulus-side bundle for seq_emitter: run request/config in, symbol stream and status out.
interface seq_emitter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             abort;
  logic [1:0]       num;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent;

  modport master (output start, reps, gap, abort, input num, busy, done, sent);
  modport slave  (input start, reps, gap, abort, output num, busy, done, sent);
endinterface

// File: rtl/seq_emitter.sv
// Emits reps copies of the 01,10,11 pattern, each symbol held HOLD cycles,
// with gap idle cycles between patterns. Abortable; reports sent count and done.
module seq_emitter #(
  parameter int unsigned HOLD  = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_emitter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSym1, StSym2, StSym3, StGap} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [1:0]       num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             hold_end;
  logic [CNT_W-1:0] sent_inc;

  assign hold_end = (hold_q == HoldLast);
  assign sent_inc = sent_q + 1'b1;

  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    hold_d  = hold_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.reps != '0)) begin
          reps_d  = bus.reps;
          gap_d   = bus.gap;
          sent_d  = '0;
          hold_d  = '0;
          gcnt_d  = '0;
          state_d = StSym1;
        end
      end
      StSym1: begin
        if (hold_end) begin
          hold_d  = '0;
          state_d = StSym2;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StSym2: begin
        if (hold_end) begin
          hold_d  = '0;
          state_d = StSym3;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StSym3: begin
        if (hold_end) begin
          hold_d = '0;
          sent_d = sent_inc;
          if (sent_inc == reps_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            state_d = StSym1;
          end else begin
            gcnt_d  = '0;
            state_d = StGap;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StGap: begin
        if (gcnt_q == gap_q - 1'b1) begin
          gcnt_d  = '0;
          state_d = StSym1;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything above but keeps the partial sent count.
    if ((state_q != StIdle) && bus.abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
      sent_d  = sent_q;
      hold_d  = '0;
      gcnt_d  = '0;
    end

    busy_d = (state_d != StIdle);
    case (state_d)
      StSym1:  num_d = 2'b01;
      StSym2:  num_d = 2'b10;
      StSym3:  num_d = 2'b11;
      default: num_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      reps_q  <= '0;
      gap_q   <= '0;
      sent_q  <= '0;
      hold_q  <= '0;
      gcnt_q  <= '0;
      num_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
      hold_q  <= hold_d;
      gcnt_q  <= gcnt_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.num  = num_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sent = sent_q;

endmodule
